pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register that generalises the fixed-field stage latches (IF/ID … M/WB) into one reusable block.
- Carries an arbitrary DATA_W payload under a valid/ready handshake, replacing the shared iHit||dHit global enable.
- A two-entry skid buffer lets back-pressure propagate one cycle late without losing data.
- A synchronous flush inserts a bubble (NOP_VAL payload).
- Instantiated between every pair of stages in the next-generation pipeline.

---
 rtl/pipe_skid_stage.sv | 116 +++++++++++
 tb/tb_pipe_skid_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: reusable pipeline stage register with a valid/ready handshake.
// A main entry drives the outputs. A skid entry catches the one payload that
// arrives in the cycle after back-pressure appears, because in_ready is registered.
// A synchronous flush empties both entries and turns the stage into a bubble (NOP_VAL).
// Optional feature: define PIPE_STALL_CNT_EN to build the saturating stall-cycle
// counter. When it is not defined, stall_cnt reads 0 and stall_clr is ignored.
module pipe_skid_stage #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                CNT_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              acc, dq;

  // in_ready comes only from registered state, so it never sees out_ready
  // combinationally.
  assign in_ready  = !skid_valid_q;
  assign acc       = in_valid && in_ready;
  assign dq        = main_valid_q && out_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Next-state for the two entries. Flush has top priority. After it, the
  // entries behave as a strict two-deep FIFO.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = NOP_VAL;
      skid_valid_d = 1'b0;
      skid_data_d  = NOP_VAL;
    end else if (!main_valid_q) begin
      if (acc) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end
    end else if (dq) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_data_d  = NOP_VAL;
      end else if (acc) begin
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
        main_data_d  = NOP_VAL;
      end
    end else if (!skid_valid_q && acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // Entry registers. An empty entry always holds NOP_VAL.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_valid_q <= 1'b0;
      main_data_q  <= NOP_VAL;
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_VAL;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a valid output is blocked. Clear takes priority and the
  // count stops at all-ones. Flush does not reset the count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr)
      stall_cnt_d = '0;
    else if (main_valid_q && !out_ready && !flush && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_stall_clr;
  assign unused_stall_clr = stall_clr;
  assign stall_cnt        = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage. A queue models the stage contents.
// The bench pushes to the queue on accept and pops it on dequeue, and checks
// the outputs against the queue every cycle.
module tb_pipe_skid_stage;
  localparam int          DW  = 32;
  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'hDEADBEEF;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  logic [DW-1:0] q[$];
  int            cnt_m;
  bit            last_acc;
  int            n_cmp = 0;
  int            n_err = 0;

  pipe_skid_stage #(.DATA_W(DW), .NOP_VAL(NOP), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare the outputs against the model at negedge, then update the model
  // and advance to 1 time unit past the next rising edge.
  task automatic step();
    bit acc, dq, stall;
    @(negedge CLK);
    check_eq("occupancy", occupancy, q.size());
    check_eq("in_ready", in_ready, q.size() < 2);
    check_eq("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) check_eq("out_data", out_data, q[0]);
    else              check_eq("nop_data", out_data, NOP);
    check_eq("stall_cnt", stall_cnt, cnt_m);
    acc   = in_valid && (q.size() < 2);
    dq    = (q.size() > 0) && out_ready;
    stall = (q.size() > 0) && !out_ready && !flush;
    last_acc = acc && !flush;
    if (flush) q.delete();
    else begin
      if (dq)  void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
`ifdef PIPE_STALL_CNT_EN
    if (stall_clr) cnt_m = 0;
    else if (stall && cnt_m != (1 << CW) - 1) cnt_m++;
`else
    if (stall) cnt_m = 0;
`endif
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int guard;
    nRST = 1'b0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0; stall_clr = 0;
    cnt_m = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_data", out_data, NOP);
    nRST = 1'b1;
    step();

    // Pass-through with one cycle of latency.
    out_ready = 1;
    in_valid  = 1; in_data = 32'hA; step();
    check_eq("t1_out_a", out_data, 32'hA);
    in_data = 32'hB; step();
    check_eq("t1_out_b", out_data, 32'hB);
    in_data = 32'hC; step();
    check_eq("t1_out_c", out_data, 32'hC);
    check_eq("t1_in_ready", in_ready, 1);
    in_valid = 0;
    repeat (2) step();

    // Back-pressure fills the skid entry. The held third payload waits until
    // there is room.
    out_ready = 0;
    in_valid = 1; in_data = 32'h11; step();
    in_data = 32'h22; step();
    check_eq("t2_occ2", occupancy, 2);
    check_eq("t2_not_ready", in_ready, 0);
    in_data = 32'h33; out_ready = 1;
    guard = 0;
    while (in_valid && guard < 10) begin
      step();
      guard++;
      if (last_acc) in_valid = 0;
    end
    check_eq("t2_acc_33", in_valid, 0);
    repeat (4) step();
    check_eq("t2_drained", out_valid, 0);

    // Flush with both entries full and a valid input present.
    out_ready = 0;
    in_valid = 1; in_data = 32'h55; step();
    in_data = 32'h66; step();
    flush = 1; in_data = 32'h44; step();
    flush = 0; in_valid = 0;
    check_eq("t3_out_valid", out_valid, 0);
    check_eq("t3_out_data", out_data, NOP);
    check_eq("t3_occ", occupancy, 0);
    check_eq("t3_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (3) step();

    // Asserting reset in mid-cycle clears the outputs at once.
    out_ready = 0;
    in_valid = 1; in_data = 32'h77; step();
    in_data = 32'h88; step();
    in_valid = 0;
    #2 nRST = 1'b0;
    #1;
    check_eq("t4_occ", occupancy, 0);
    check_eq("t4_out_valid", out_valid, 0);
    check_eq("t4_out_data", out_data, NOP);
    check_eq("t4_in_ready", in_ready, 1);
    q.delete(); cnt_m = 0;
    @(posedge CLK); #1 nRST = 1'b1;
    step();

    // Stall counter saturation and clear.
    stall_clr = 1; step(); stall_clr = 0;
    in_valid = 1; in_data = 32'h99; step(); in_valid = 0;
    repeat (20) step();
`ifdef PIPE_STALL_CNT_EN
    check_eq("t6_sat", stall_cnt, 15);
`else
    check_eq("t6_off", stall_cnt, 0);
`endif
    stall_clr = 1; step(); stall_clr = 0;
    check_eq("t6_clr", stall_cnt, 0);
    out_ready = 1; repeat (2) step();

    // Random traffic. The upstream side keeps its payload until it is accepted.
    in_valid = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom & 32'h7FFF_FFFF;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      stall_clr = ($urandom_range(0, 31) == 0);
      step();
    end
    in_valid = 0; flush = 0; stall_clr = 0; out_ready = 1;
    repeat (3) step();
    check_eq("final_empty", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
